fetch_redirect_unit: RTL and testbench

- Front-end PC owner that consumes the branch/jump redirect (success + new_address) produced by the EX-stage branch comparator.
- Holds the fetch PC, advances it by 4 each accepted fetch, and loads the redirect target when a redirect is accepted.
- Issues IF/ID and ID/EX flush pulses for the squashed younger instructions.
- Buffers a redirect that arrives while instruction memory is not ready, and counts taken redirects.

---
 rtl/fetch_redirect_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_redirect_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_unit.sv
// Front-end fetch PC owner: advances the PC, applies EX-stage branch/jump redirects,
// squashes younger instructions and parks a redirect until instruction memory is ready.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC      = 32'h00400000,
    parameter int          SQUASH_CYCLES = 1,
    parameter int          CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             redirect_valid,
    input  logic [31:0]      redirect_target,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             redirect_pending,
    output logic [CNT_W-1:0] redirect_count,
    output logic             misaligned_err
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        SQUASH = 2'd2,
        PEND   = 2'd3
    } state_t;

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    state_t             state_r;
    state_t             state_s;
    logic [31:0]        pc_r;
    logic [31:0]        pc_s;
    logic [2:0]         sq_cnt_r;
    logic [2:0]         sq_cnt_s;
    logic [31:0]        pend_tgt_r;
    logic [31:0]        pend_tgt_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_s;
    logic               mis_r;
    logic               mis_s;
    logic               pending_r;
    logic               fetch_valid_s;
    logic               flush_s;
    logic               accept_s;
    logic [31:0]        target_s;
    logic [31:0]        pc_plus4_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign target_s   = {redirect_target[31:2], 2'b00};
    assign accept_s   = redirect_valid & (state_r != BOOT);

    // Next-state, next-PC and same-cycle fetch/flush outputs
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        sq_cnt_s      = sq_cnt_r;
        pend_tgt_s    = pend_tgt_r;
        count_s       = count_r;
        mis_s         = mis_r;
        fetch_valid_s = 1'b0;
        flush_s       = 1'b0;

        case (state_r)
            BOOT: begin
                state_s = RUN;
            end
            RUN: begin
                fetch_valid_s = imem_ready & ~stall;
                if (fetch_valid_s) begin
                    pc_s = pc_plus4_s;
                end else begin
                    pc_s = pc_r;
                end
            end
            SQUASH: begin
                if (stall) begin
                    sq_cnt_s = sq_cnt_r;
                end else if (sq_cnt_r <= 3'd1) begin
                    sq_cnt_s = 3'd0;
                    state_s  = RUN;
                end else begin
                    sq_cnt_s = sq_cnt_r - 3'd1;
                end
            end
            PEND: begin
                if (imem_ready && !stall) begin
                    pc_s    = pend_tgt_r;
                    count_s = count_r + CNT_W'(1);
                    if (SQ_LOAD != 3'd0) begin
                        state_s  = SQUASH;
                        sq_cnt_s = SQ_LOAD;
                    end else begin
                        state_s  = RUN;
                        sq_cnt_s = 3'd0;
                    end
                end else begin
                    state_s = PEND;
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase

        // An accepted redirect overrides stall and whatever the state chose above
        if (accept_s) begin
            flush_s = 1'b1;
            if (redirect_target[1:0] != 2'b00) begin
                mis_s = 1'b1;
            end else begin
                mis_s = mis_r;
            end
            if (imem_ready) begin
                pc_s    = target_s;
                count_s = count_r + CNT_W'(1);
                if (SQ_LOAD != 3'd0) begin
                    state_s  = SQUASH;
                    sq_cnt_s = SQ_LOAD;
                end else begin
                    state_s  = RUN;
                    sq_cnt_s = 3'd0;
                end
            end else begin
                pc_s       = pc_r;
                count_s    = count_r;
                pend_tgt_s = target_s;
                state_s    = PEND;
            end
        end else begin
            flush_s = 1'b0;
        end
    end

    // State, PC, pending target, counters and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= BOOT;
            pc_r       <= RESET_PC;
            sq_cnt_r   <= 3'd0;
            pend_tgt_r <= 32'd0;
            count_r    <= '0;
            mis_r      <= 1'b0;
            pending_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            sq_cnt_r   <= sq_cnt_s;
            pend_tgt_r <= pend_tgt_s;
            count_r    <= count_s;
            mis_r      <= mis_s;
            pending_r  <= (state_s == PEND);
        end
    end

    assign pc               = pc_r;
    assign pc_plus4         = pc_plus4_s;
    assign fetch_valid      = fetch_valid_s;
    assign flush_if_id      = flush_s;
    assign flush_id_ex      = flush_s;
    assign redirect_pending = pending_r;
    assign redirect_count   = count_r;
    assign misaligned_err   = mis_r;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: directed plan followed by random traffic, two instances
// (default parameters, and a 3-bit count with no squash) checked against a cycle model.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        imem_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;

    logic [31:0] pc_o    [2];
    logic [31:0] pc4_o   [2];
    logic        fv_o    [2];
    logic        fif_o   [2];
    logic        fex_o   [2];
    logic        pend_o  [2];
    logic        mis_o   [2];
    logic [31:0] cnt_a;
    logic [2:0]  cnt_b;

    int tests = 0;
    int fails = 0;

    // Reference state, one slot per instance
    logic [31:0] m_pc   [2];
    logic [31:0] m_tgt  [2];
    logic [31:0] m_cnt  [2];
    bit          m_boot [2];
    bit          m_pend [2];
    bit          m_mis  [2];
    int          m_sq   [2];
    int          sc     [2] = '{1, 0};
    logic [31:0] mask   [2] = '{32'hFFFF_FFFF, 32'h0000_0007};

    always #5 clk = ~clk;

    fetch_redirect_unit dut_a (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pc(pc_o[0]), .pc_plus4(pc4_o[0]), .fetch_valid(fv_o[0]),
        .flush_if_id(fif_o[0]), .flush_id_ex(fex_o[0]), .redirect_pending(pend_o[0]),
        .redirect_count(cnt_a), .misaligned_err(mis_o[0])
    );

    fetch_redirect_unit #(.SQUASH_CYCLES(0), .CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .pc(pc_o[1]), .pc_plus4(pc4_o[1]), .fetch_valid(fv_o[1]),
        .flush_if_id(fif_o[1]), .flush_id_ex(fex_o[1]), .redirect_pending(pend_o[1]),
        .redirect_count(cnt_b), .misaligned_err(mis_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h0040_0000; m_tgt[i] = 32'd0; m_cnt[i] = 32'd0;
            m_boot[i] = 1'b1; m_pend[i] = 1'b0; m_mis[i] = 1'b0; m_sq[i] = 0;
        end
    endtask

    task automatic check_all();
        logic [31:0] cnt_obs [2];
        bit exp_fv;
        bit exp_fl;
        cnt_obs[0] = cnt_a;
        cnt_obs[1] = {29'd0, cnt_b};
        for (int i = 0; i < 2; i++) begin
            exp_fv = !reset && !m_boot[i] && !m_pend[i] && (m_sq[i] == 0) && imem_ready && !stall;
            exp_fl = !reset && !m_boot[i] && redirect_valid;
            check($sformatf("pc%0d", i), pc_o[i], m_pc[i]);
            check($sformatf("pc_plus4_%0d", i), pc4_o[i], m_pc[i] + 32'd4);
            check($sformatf("fetch_valid%0d", i), {31'd0, fv_o[i]}, {31'd0, exp_fv});
            check($sformatf("flush_if_id%0d", i), {31'd0, fif_o[i]}, {31'd0, exp_fl});
            check($sformatf("flush_id_ex%0d", i), {31'd0, fex_o[i]}, {31'd0, exp_fl});
            check($sformatf("pending%0d", i), {31'd0, pend_o[i]}, {31'd0, m_pend[i]});
            check($sformatf("count%0d", i), cnt_obs[i], m_cnt[i]);
            check($sformatf("misaligned%0d", i), {31'd0, mis_o[i]}, {31'd0, m_mis[i]});
        end
    endtask

    task automatic model_edge(input bit s, input bit r, input bit v, input logic [31:0] t);
        logic [31:0] ta;
        ta = {t[31:2], 2'b00};
        for (int i = 0; i < 2; i++) begin
            if (m_boot[i]) begin
                m_boot[i] = 1'b0;
            end else if (v) begin
                if (t[1:0] != 2'b00) m_mis[i] = 1'b1;
                if (r) begin
                    m_pc[i] = ta; m_cnt[i] = (m_cnt[i] + 32'd1) & mask[i];
                    m_pend[i] = 1'b0; m_sq[i] = sc[i];
                end else begin
                    m_pend[i] = 1'b1; m_tgt[i] = ta;
                end
            end else if (m_pend[i]) begin
                if (r && !s) begin
                    m_pc[i] = m_tgt[i]; m_cnt[i] = (m_cnt[i] + 32'd1) & mask[i];
                    m_pend[i] = 1'b0; m_sq[i] = sc[i];
                end
            end else if (m_sq[i] > 0) begin
                if (!s) m_sq[i] = m_sq[i] - 1;
            end else if (r && !s) begin
                m_pc[i] = m_pc[i] + 32'd4;
            end
        end
    endtask

    // Called just after a falling edge: drive, check, clock, move to the next falling edge
    task automatic step(input bit s, input bit r, input bit v, input logic [31:0] t);
        stall = s; imem_ready = r; redirect_valid = v; redirect_target = t;
        #1;
        check_all();
        @(posedge clk);
        model_edge(s, r, v, t);
        @(negedge clk);
    endtask

    task automatic do_reset();
        #1;
        reset = 1'b1; stall = 1'b0; imem_ready = 1'b1; redirect_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();
        // boot cycle, then three sequential fetches
        step(0, 1, 0, 32'd0);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 32'd0);
        // taken branch at 0x0040000C, then squash
        step(0, 1, 1, 32'h0040_0100);
        step(0, 1, 0, 32'd0);
        step(0, 1, 0, 32'd0);
        // redirect beats stall
        step(1, 1, 1, 32'h0040_0200);
        step(1, 1, 0, 32'd0);
        step(0, 1, 0, 32'd0);
        step(0, 1, 0, 32'd0);
        // redirect parked while memory busy, overwritten, applied once
        step(0, 0, 1, 32'h0040_0300);
        step(0, 0, 1, 32'h0040_0400);
        step(0, 0, 0, 32'd0);
        step(0, 0, 0, 32'd0);
        step(0, 1, 0, 32'd0);
        step(0, 1, 0, 32'd0);
        step(0, 1, 0, 32'd0);
        // misaligned target
        step(0, 1, 1, 32'h0040_0106);
        for (int k = 0; k < 3; k++) step(0, 1, 0, 32'd0);
        // reset while pending
        step(0, 0, 1, 32'h0040_0500);
        step(0, 0, 0, 32'd0);
        do_reset();
        step(0, 1, 1, 32'h0040_0700);
        step(0, 1, 0, 32'd0);
        // count wrap on the narrow instance
        for (int k = 0; k < 9; k++) begin
            step(0, 1, 1, 32'h0040_1000 + 32'(k) * 32'd16);
            step(0, 1, 0, 32'd0);
        end
        // PC wrap at the top of the address space
        step(0, 1, 1, 32'hFFFF_FFF8);
        for (int k = 0; k < 4; k++) step(0, 1, 0, 32'd0);
        // random traffic
        for (int k = 0; k < 400; k++) begin
            logic [31:0] t;
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 4) == 0, t);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
